// File: rtl/serial_sum_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : serial_sum_ctrl
// Brief   : Bit-serial WIDTH-bit adder sequencing one 1-bit lookahead cell,
//           LSB first, framed by a start/busy/done handshake.
// Revision: 1.0 - initial release
// ============================================================================
module serial_sum_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_c_out;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic w_s;
  logic w_g;
  logic w_p;
  logic w_cout;
  logic w_last;

  // The single shared 1-bit lookahead cell.
  always_comb begin
    w_p    = r_a[0] ^ r_b[0];
    w_g    = r_a[0] & r_b[0];
    w_s    = w_p ^ r_carry;
    w_cout = w_g | (w_p & r_carry);
  end

  assign w_last = (r_cnt == c_last);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == ST_RUN);
      r_done  <= (w_next == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_c_out  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_a      <= a_in;
        r_b      <= b_in;
        r_carry  <= c_in;
        r_sum_sh <= '0;
        r_cnt    <= '0;
      end else if (r_state == ST_RUN) begin
        r_a      <= r_a >> 1;
        r_b      <= r_b >> 1;
        r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
        r_carry  <= w_cout;
        r_cnt    <= r_cnt + 1'b1;
        // Result register is loaded only once the final bit is through,
        // so partial shift contents never reach the sum output.
        if (w_last) begin
          r_sum   <= {w_s, r_sum_sh[WIDTH-1:1]};
          r_c_out <= w_cout;
          r_ovf   <= r_carry ^ w_cout;
        end
      end
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign c_out = r_c_out;
  assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_sum_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_sum_ctrl
// Brief   : Directed plus randomized checks of serial_sum_ctrl against an
//           arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_sum_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  int total = 0;
  int bad   = 0;

  serial_sum_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition; overflow from the carry into the MSB.
  function automatic logic [WIDTH+1:0] model(input int a, input int b, input int cin);
    int full;
    int low;
    int cmsb;
    int cout;
    full = a + b + cin;
    low  = (a % (1 << (WIDTH - 1))) + (b % (1 << (WIDTH - 1))) + cin;
    cmsb = (low >> (WIDTH - 1)) & 1;
    cout = (full >> WIDTH) & 1;
    return {1'(cmsb ^ cout), 1'(cout), WIDTH'(full % (1 << WIDTH))};
  endfunction

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input bit scramble, input string tag);
    logic [WIDTH+1:0] exp;
    int k;
    int busy_cnt;
    int extra;
    bit got;
    exp = model(int'(a), int'(b), int'(cin));
    @(negedge clk);
    a_in = a; b_in = b; c_in = cin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); c_in = 1'($urandom);
    k = 0; busy_cnt = 0; got = 0;
    while (k < 4 * WIDTH && !got) begin
      @(negedge clk);
      k++;
      if (scramble && k == 3) begin start = 1'b1; a_in = 8'hFF; b_in = 8'hFF; end
      if (scramble && k == 5) start = 1'b0;
      if (done) got = 1;
      else if (busy) busy_cnt++;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(k), 32'(WIDTH + 1));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
    check({tag, "_busy_with_done"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(exp[WIDTH-1:0]));
    check({tag, "_c_out"}, 32'(c_out), 32'(exp[WIDTH]));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp[WIDTH+1]));
    extra = 0;
    repeat (WIDTH + 3) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({tag, "_single_done"}, 32'(extra), 32'd0);
    check({tag, "_sum_held"}, 32'(sum), 32'(exp[WIDTH-1:0]));
  endtask

  initial begin : main
    logic [WIDTH+1:0] exp;
    int k;
    int ndone;
    int last_k;
    int dones_in_reset;

    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_c_out", 32'(c_out), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    do_op(8'h00, 8'h00, 1'b0, 0, "zero");
    do_op(8'hFF, 8'h01, 1'b0, 0, "ff_plus_1");
    do_op(8'h7F, 8'h01, 1'b0, 0, "7f_plus_1");
    do_op(8'h5A, 8'hA5, 1'b1, 1, "5a_a5_scramble");

    for (int i = 0; i < 20; i++)
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), (i % 4) == 0, "rand");
    do_op(8'hC3, 8'h0F, 1'b1, 0, "pre_reset");

    // Abort an operation with asynchronous reset while bit 3 is in flight.
    @(negedge clk);
    a_in = 8'h12; b_in = 8'h34; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun_busy_before_rst", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_sum", 32'(sum), 32'd0);
    check("async_rst_c_out", 32'(c_out), 32'd0);
    check("async_rst_ovf", 32'(ovf), 32'd0);
    dones_in_reset = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones_in_reset++;
    end
    rst_n = 1'b1;
    repeat (WIDTH + 2) begin
      @(negedge clk);
      if (done || busy) dones_in_reset++;
    end
    check("rst_discards_op", 32'(dones_in_reset), 32'd0);
    do_op(8'h12, 8'h34, 1'b0, 0, "after_reset");

    // Continuous start: back-to-back operations every WIDTH+2 edges.
    exp = model(32'h80, 32'h80, 0);
    @(negedge clk);
    a_in = 8'h80; b_in = 8'h80; c_in = 1'b0; start = 1'b1;
    k = 0; ndone = 0; last_k = -1;
    while (k < 80 && ndone < 4) begin
      @(negedge clk);
      k++;
      if (done) begin
        ndone++;
        check("b2b_sum", 32'(sum), 32'(exp[WIDTH-1:0]));
        check("b2b_c_out", 32'(c_out), 32'(exp[WIDTH]));
        check("b2b_ovf", 32'(ovf), 32'(exp[WIDTH+1]));
        if (last_k >= 0) check("b2b_spacing", 32'(k - last_k), 32'(WIDTH + 2));
        last_k = k;
      end else if (ndone > 0) begin
        check("b2b_sum_stable", 32'({c_out, sum}), 32'({exp[WIDTH], exp[WIDTH-1:0]}));
      end
    end
    start = 1'b0;
    check("b2b_done_count", 32'(ndone), 32'd4);
    repeat (3) @(negedge clk);
    check("b2b_idle_after", 32'({busy, done}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
